// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller slice.
// Contents:
//   - ERR_W: width of the receiver error flags.
//   - rx_state_e: the controller FSM state encoding.
//   - Baud and parity code constants driven to the receiver.
//   - rx_frame_t: the byte/tag pair stored in each receive FIFO entry.
package uart_pkg;

    localparam int ERR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_COMMIT = 2'd3
    } rx_state_e;

    // Baud codes understood by the receiver
    localparam logic [1:0] BAUD_9600   = 2'b00;
    localparam logic [1:0] BAUD_19200  = 2'b01;
    localparam logic [1:0] BAUD_57600  = 2'b10;
    localparam logic [1:0] BAUD_115200 = 2'b11;

    // Parity codes understood by the receiver
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    typedef struct packed {
        logic [7:0]       data;
        logic [ERR_W-1:0] err;
    } rx_frame_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive-byte output stream of the UART receive controller.
// Signals:
//   out_valid  FIFO head is valid
//   out_ready  consumer accepts the head when high together with out_valid
//   out_data   FIFO head byte
//   out_err    FIFO head error tag
// Modports:
//   master  producer side (the controller)
//   slave   consumer side
interface uart_rx_ctrl_if;
    import uart_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [ERR_W-1:0] out_err;

    modport master (output out_valid, out_data, out_err, input  out_ready);
    modport slave  (input  out_valid, out_data, out_err, output out_ready);

endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for the UART receive controller.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   push_i     write wdata_i this cycle
//   wdata_i    frame to store
//   pop_i      consumer takes the head this cycle (ignored when empty)
//   rdata_o    head entry, zero when empty
//   valid_o    FIFO non-empty
//   count_o    occupancy, 0..DEPTH
//   drop_o     push refused because full with no simultaneous pop
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  rx_frame_t                wdata_i,
    input  logic                     pop_i,
    output rx_frame_t                rdata_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    rx_frame_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q;
    logic              full, do_pop, do_push;

    assign full    = (cnt_q == CW'(DEPTH));
    assign valid_o = (cnt_q != '0);
    assign do_pop  = pop_i & valid_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_i & (~full | do_pop);
    assign drop_o  = push_i & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is not reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = valid_o ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sequences deframed bytes from the receiver into a
// receive FIFO, tracks errored frames and overflow, and applies baud/parity
// configuration only between frames.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   cfg_wr        one-cycle strobe writing cfg_baud/cfg_parity
//   cfg_baud      requested baud code
//   cfg_parity    requested parity code
//   rx_active     receiver frame-in-progress flag
//   rx_done       receiver frame-done level (edge detected here)
//   rx_data       receiver deframed byte
//   rx_error      receiver error flags, nonzero = errored frame
//   baud_rate     applied baud code
//   parity_type   applied parity code
//   out_if        FIFO head stream (uart_rx_ctrl_if.master)
//   fifo_count    FIFO occupancy
//   overflow      sticky: a frame was lost to a full FIFO
//   err_cnt       saturating count of errored frames
//   cfg_pending   a config write awaits application
// Build option:
//   UART_RX_CTRL_DROP_ERR_EN  errored frames are counted but not stored;
//                             out_err is then always zero.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int         DEPTH      = 4,
    parameter logic [1:0] DEF_BAUD   = BAUD_57600,
    parameter logic [1:0] DEF_PARITY = PAR_NONE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_wr,
    input  logic [1:0]               cfg_baud,
    input  logic [1:0]               cfg_parity,
    input  logic                     rx_active,
    input  logic                     rx_done,
    input  logic [7:0]               rx_data,
    input  logic [ERR_W-1:0]         rx_error,
    output logic [1:0]               baud_rate,
    output logic [1:0]               parity_type,
    uart_rx_ctrl_if.master           out_if,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               err_cnt,
    output logic                     cfg_pending
);

    rx_state_e  state_q;
    logic       done_q;
    logic       done_rise;
    logic       commit;
    logic       frm_err;
    logic       push, pop, drop;
    logic       head_vld;
    rx_frame_t  wdata, head;

    logic [1:0] baud_q, par_q;
    logic [1:0] hold_baud_q, hold_par_q;
    logic       pend_q;
    logic       ovf_q;
    logic [7:0] err_cnt_q;

    assign done_rise = rx_done & ~done_q;
    assign commit    = (state_q == ST_COMMIT);
    assign frm_err   = |rx_error;

`ifdef UART_RX_CTRL_DROP_ERR_EN
    assign push  = commit & ~frm_err;
    assign wdata = '{data: rx_data, err: '0};
`else
    assign push  = commit;
    assign wdata = '{data: rx_data, err: rx_error};
`endif

    assign pop = head_vld & out_if.out_ready;

    uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (head),
        .valid_o (head_vld),
        .count_o (fifo_count),
        .drop_o  (drop)
    );

    // Frame sequencer. SETTLE gives the receiver's registered error flags one
    // cycle to settle before COMMIT samples them. A rising edge seen in IDLE
    // wins over rx_active so a short frame is never missed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= rx_done;
            case (state_q)
                ST_IDLE: begin
                    if (done_rise)      state_q <= ST_SETTLE;
                    else if (rx_active) state_q <= ST_RECV;
                end
                ST_RECV: begin
                    if (done_rise) state_q <= ST_SETTLE;
                end
                ST_SETTLE: state_q <= ST_COMMIT;
                ST_COMMIT: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // Error counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (commit && frm_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            if (drop) ovf_q <= 1'b1;
        end
    end

    // Config is applied only while the receiver is between frames. COMMIT
    // always returns to IDLE, so the COMMIT edge is where held values land;
    // a write arriving in COMMIT itself is taken straight through.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q      <= DEF_BAUD;
            par_q       <= DEF_PARITY;
            hold_baud_q <= DEF_BAUD;
            hold_par_q  <= DEF_PARITY;
            pend_q      <= 1'b0;
        end else if (state_q == ST_IDLE && (cfg_wr || pend_q)) begin
            baud_q <= cfg_wr ? cfg_baud   : hold_baud_q;
            par_q  <= cfg_wr ? cfg_parity : hold_par_q;
            pend_q <= 1'b0;
        end else if (commit && (cfg_wr || pend_q)) begin
            baud_q <= cfg_wr ? cfg_baud   : hold_baud_q;
            par_q  <= cfg_wr ? cfg_parity : hold_par_q;
            pend_q <= 1'b0;
        end else if (cfg_wr) begin
            hold_baud_q <= cfg_baud;
            hold_par_q  <= cfg_parity;
            pend_q      <= 1'b1;
        end
    end

    assign out_if.out_valid = head_vld;
    assign out_if.out_data  = head.data;
    assign out_if.out_err   = head.err;

    assign baud_rate   = baud_q;
    assign parity_type = par_q;
    assign cfg_pending = pend_q;
    assign overflow    = ovf_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl (DEPTH=4, default config codes).
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cfg_wr, rx_active, rx_done;
    logic [1:0] cfg_baud, cfg_parity;
    logic [7:0] rx_data;
    logic [2:0] rx_error;
    logic [1:0] baud_rate, parity_type;
    logic [2:0] fifo_count;
    logic       overflow, cfg_pending;
    logic [7:0] err_cnt;

    uart_rx_ctrl_if oif ();

    uart_rx_ctrl #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_wr      (cfg_wr),
        .cfg_baud    (cfg_baud),
        .cfg_parity  (cfg_parity),
        .rx_active   (rx_active),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .rx_error    (rx_error),
        .baud_rate   (baud_rate),
        .parity_type (parity_type),
        .out_if      (oif),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .err_cnt     (err_cnt),
        .cfg_pending (cfg_pending)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One frame: optional RECV phase, rx_done rises, SETTLE, COMMIT (optional
    // pop in the COMMIT cycle), then rx_done drops. Ends back in IDLE.
    task automatic frame(input logic [7:0] d, input logic [2:0] e, input bit recv, input bit pop);
        if (recv) begin
            rx_active = 1'b1; step; step; rx_active = 1'b0;
        end
        rx_done = 1'b1; rx_data = d; rx_error = e;
        step;                       // now SETTLE
        step;                       // now COMMIT
        oif.out_ready = pop;
        step;                       // push done, now IDLE
        oif.out_ready = 1'b0;
        rx_done = 1'b0; rx_data = '0; rx_error = '0;
        step;
    endtask

    task automatic pop_one;
        oif.out_ready = 1'b1; step; oif.out_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [2:0] err;
        logic [7:0] exp_data;
        logic [2:0] exp_err;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{8'hA5, 3'b000, 8'hA5, 3'b000};
        tbl[1] = '{8'h3C, 3'b000, 8'h3C, 3'b000};
        tbl[2] = '{8'h5A, 3'b000, 8'h5A, 3'b000};
        tbl[3] = '{8'hFF, 3'b000, 8'hFF, 3'b000};
        tbl[4] = '{8'h01, 3'b000, 8'h01, 3'b000};

        rst = 1'b1; cfg_wr = 1'b0; cfg_baud = '0; cfg_parity = '0;
        rx_active = 1'b0; rx_done = 1'b0; rx_data = '0; rx_error = '0;
        oif.out_ready = 1'b0;
        step; step;

        // Reset state
        chk("rst_valid",   oif.out_valid, 0);
        chk("rst_data",    oif.out_data,  0);
        chk("rst_err",     oif.out_err,   0);
        chk("rst_count",   fifo_count,    0);
        chk("rst_ovf",     overflow,      0);
        chk("rst_errcnt",  err_cnt,       0);
        chk("rst_pending", cfg_pending,   0);
        chk("rst_baud",    baud_rate,     2'b10);
        chk("rst_parity",  parity_type,   2'b00);
        rst = 1'b0; step;

        // Single clean frame, latency and level-held rx_done
        rx_done = 1'b1; rx_data = 8'hA5; rx_error = '0;
        step; step;
        chk("commit_valid_low", oif.out_valid, 0);
        step;
        chk("a5_valid", oif.out_valid, 1);
        chk("a5_data",  oif.out_data,  8'hA5);
        chk("a5_count", fifo_count,    1);
        chk("a5_err",   oif.out_err,   0);
        step; step; step;
        chk("level_no_repush", fifo_count, 1);
        rx_done = 1'b0; step;
        pop_one;
        chk("pop_count", fifo_count,    0);
        chk("pop_valid", oif.out_valid, 0);
        pop_one;
        chk("pop_empty_count", fifo_count, 0);

        // Fill to full, then push+pop together while full
        for (int i = 0; i < 4; i++) frame(tbl[i].data, tbl[i].err, 1'b1, 1'b0);
        chk("full_count", fifo_count, 4);
        chk("full_ovf",   overflow,   0);
        frame(tbl[4].data, tbl[4].err, 1'b1, 1'b1);
        chk("pushpop_count", fifo_count, 4);
        chk("pushpop_ovf",   overflow,   0);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("drain_data%0d", i), oif.out_data, tbl[i].exp_data);
            chk($sformatf("drain_err%0d", i),  oif.out_err,  tbl[i].exp_err);
            pop_one;
            chk($sformatf("drain_count%0d", i), fifo_count, 4 - i);
        end

        // Five frames with no consumer: fifth is lost
        for (int i = 0; i < 5; i++) frame(tbl[i].data, tbl[i].err, 1'b0, 1'b0);
        chk("ovf_count", fifo_count,   4);
        chk("ovf_flag",  overflow,     1);
        chk("ovf_head",  oif.out_data, tbl[0].exp_data);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_drain%0d", i), oif.out_data, tbl[i].exp_data);
            pop_one;
        end
        chk("ovf_sticky", overflow,   1);
        chk("ovf_empty",  fifo_count, 0);

        // Config write in IDLE applies next cycle
        cfg_wr = 1'b1; cfg_baud = 2'b11; cfg_parity = 2'b01;
        step; cfg_wr = 1'b0;
        chk("idle_cfg_baud",    baud_rate,   2'b11);
        chk("idle_cfg_parity",  parity_type, 2'b01);
        chk("idle_cfg_pending", cfg_pending, 0);

        // Config writes mid-frame are held; last one wins at IDLE
        rx_active = 1'b1; step;
        cfg_wr = 1'b1; cfg_baud = 2'b00; cfg_parity = 2'b00; step;
        cfg_baud = 2'b01; cfg_parity = 2'b10; step;
        cfg_wr = 1'b0;
        chk("recv_pending", cfg_pending, 1);
        chk("recv_baud",    baud_rate,   2'b11);
        rx_active = 1'b0; rx_done = 1'b1; rx_data = 8'h11;
        step; step;
        chk("commit_pending", cfg_pending, 1);
        chk("commit_baud",    baud_rate,   2'b11);
        step;
        chk("applied_baud",    baud_rate,   2'b01);
        chk("applied_parity",  parity_type, 2'b10);
        chk("applied_pending", cfg_pending, 0);
        rx_done = 1'b0; step;
        pop_one;

        // Errored frame
        rst = 1'b1; step; rst = 1'b0; step;
        frame(8'h77, 3'b010, 1'b1, 1'b0);
        chk("errfrm_errcnt", err_cnt, 1);
`ifdef UART_RX_CTRL_DROP_ERR_EN
        chk("errfrm_count", fifo_count,  0);
        chk("errfrm_err",   oif.out_err, 0);
`else
        chk("errfrm_count", fifo_count,   1);
        chk("errfrm_err",   oif.out_err,  3'b010);
        chk("errfrm_data",  oif.out_data, 8'h77);
`endif

        // Reset during RECV abandons the frame
        frame(8'h42, 3'b000, 1'b0, 1'b0);
        rx_active = 1'b1; step;
        cfg_wr = 1'b1; cfg_baud = 2'b00; cfg_parity = 2'b11; step;
        cfg_wr = 1'b0;
        chk("pre_rst_pending", cfg_pending, 1);
        rst = 1'b1; step;
        chk("mid_rst_valid",   oif.out_valid, 0);
        chk("mid_rst_data",    oif.out_data,  0);
        chk("mid_rst_err",     oif.out_err,   0);
        chk("mid_rst_count",   fifo_count,    0);
        chk("mid_rst_ovf",     overflow,      0);
        chk("mid_rst_errcnt",  err_cnt,       0);
        chk("mid_rst_pending", cfg_pending,   0);
        chk("mid_rst_baud",    baud_rate,     2'b10);
        chk("mid_rst_parity",  parity_type,   2'b00);
        rx_active = 1'b0; rx_done = 1'b1; rx_data = 8'h99; step;
        rx_done = 1'b0; step;
        rst = 1'b0;
        step; step; step; step;
        chk("abandoned_no_push", fifo_count, 0);
        chk("abandoned_valid",   oif.out_valid, 0);

        // err_cnt saturation
        for (int i = 0; i < 255; i++) frame(8'h00, 3'b001, 1'b0, 1'b1);
        chk("errcnt_255", err_cnt, 8'd255);
        frame(8'h00, 3'b001, 1'b0, 1'b1);
        chk("errcnt_sat", err_cnt, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, receive FIFO entries; power of two, 2..16.
REQ-002 Parameter DEF_BAUD, default 2'b10, baud_rate code loaded at reset.
REQ-003 Parameter DEF_PARITY, default 2'b00, parity_type code loaded at reset.
REQ-004 clk  in  1  system clock; single clock domain, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cfg_wr  in  1  one-cycle strobe; writes cfg_baud/cfg_parity.
REQ-007 cfg_baud  in  2  requested baud code.
REQ-008 cfg_parity  in  2  requested parity code.
REQ-009 rx_active  in  1  receiver frame-in-progress flag.
REQ-010 rx_done  in  1  receiver frame-done level.
REQ-011 rx_data  in  8  receiver deframed byte.
REQ-012 rx_error  in  3  receiver error flags; nonzero means errored frame.
REQ-013 baud_rate  out  2  applied baud code driven to receiver.
REQ-014 parity_type  out  2  applied parity code driven to receiver.
REQ-015 out_valid  out  1  FIFO head valid.
REQ-016 out_ready  in  1  consumer accepts head when high with out_valid.
REQ-017 out_data  out  8  FIFO head byte.
REQ-018 out_err  out  3  FIFO head error tag.
REQ-019 fifo_count  out  $clog2(DEPTH)+1  current occupancy.
REQ-020 overflow  out  1  sticky: a frame was lost to a full FIFO.
REQ-021 err_cnt  out  8  saturating count of errored frames.
REQ-022 cfg_pending  out  1  a config write awaits application.

Function
REQ-023 FSM states IDLE, RECV, SETTLE, COMMIT.
REQ-024 IDLE->RECV when rx_active=1; IDLE->SETTLE on rx_done rising edge (0 previous cycle, 1 now).
REQ-025 RECV->SETTLE on rx_done rising edge; otherwise remain.
REQ-026 SETTLE lasts exactly one cycle so registered rx_error is stable; then COMMIT.
REQ-027 COMMIT samples rx_data/rx_error, performs push, returns to IDLE next cycle; push visible on out_valid 1 cycle after COMMIT.
REQ-028 A frame is counted once per rx_done rising edge; a level held high produces no further pushes.
REQ-029 Nonzero rx_error at COMMIT increments err_cnt, saturating at 255.
REQ-030 Push while full (without simultaneous pop) discards the frame and sets overflow; overflow clears only on rst.
REQ-031 Push and pop in the same cycle when full both succeed; count unchanged.
REQ-032 Pop occurs when out_valid & out_ready; pop when empty has no effect.
REQ-033 FIFO pointers wrap modulo DEPTH; fifo_count ranges 0..DEPTH.
REQ-034 cfg_wr in IDLE with no pending: baud_rate/parity_type update next cycle.
REQ-035 cfg_wr in RECV/SETTLE/COMMIT: values held, cfg_pending=1; applied on the cycle the FSM enters IDLE, cfg_pending then clears.
REQ-036 A later cfg_wr overwrites a pending one; last write wins.

Reset
REQ-037 On rst: FSM=IDLE, FIFO empty, out_valid=0, out_data=0, out_err=0, fifo_count=0, overflow=0, err_cnt=0, cfg_pending=0, baud_rate=DEF_BAUD, parity_type=DEF_PARITY, rx_done edge register=0.
REQ-038 rst mid-frame abandons the frame; no push occurs for it.

Configuration
REQ-039 Macro UART_RX_CTRL_DROP_ERR_EN defined: errored frames are counted but not pushed; out_err is always 0.
REQ-040 Macro undefined: errored frames are pushed with rx_error as out_err tag.

Structure
REQ-041 Shared package uart_pkg holds the FSM state enum, baud/parity code constants, and ERR_W=3.
REQ-042 FIFO storage/pointers are one sub-module, uart_rx_fifo; FSM, config and counters stay in uart_rx_ctrl.

Verification
REQ-043 rx_done rises with rx_data=8'hA5, rx_error=0 -> out_valid at COMMIT+1, out_data=8'hA5, fifo_count=1.
REQ-044 Five clean frames, DEPTH=4, out_ready=0 -> fifo_count=4, overflow=1, out_data=first byte.
REQ-045 cfg_wr baud=2'b01 while rx_active=1 -> cfg_pending=1, baud_rate unchanged until IDLE, then 2'b01, cfg_pending=0.
REQ-046 Frame with rx_error=3'b010 -> err_cnt=1; with DROP_ERR_EN fifo_count=0, without fifo_count=1 and out_err=3'b010.
REQ-047 rst asserted during RECV -> all outputs at reset values next cycle; later rx_done edge yields no push.
REQ-048 256 errored frames -> err_cnt=255.
